// File: rtl/legv8_multicycle_control_if.sv
// Control bundle between the LEGv8 multicycle main control FSM and its datapath.
// The controller side (master) consumes the opcode and zero flag and drives every
// datapath enable/select; the datapath side (slave) is the mirror image.
interface legv8_multicycle_control_if #(parameter int COUNT_W = 16);
  logic [10:0]        Opcode;
  logic               Zero;
  logic [1:0]         ALUop;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               PCSource;
  logic               IRWrite;
  logic               PCWrite;
  logic               MemRead;
  logic               MemWrite;
  logic               RegWrite;
  logic               MemtoReg;
  logic               Reg2Loc;
  logic               InstrDone;
  logic               Illegal;
  logic [COUNT_W-1:0] InstrCount;

  modport master (
    input  Opcode, Zero,
    output ALUop, ALUSrcA, ALUSrcB, PCSource, IRWrite, PCWrite, MemRead,
           MemWrite, RegWrite, MemtoReg, Reg2Loc, InstrDone, Illegal, InstrCount
  );

  modport slave (
    output Opcode, Zero,
    input  ALUop, ALUSrcA, ALUSrcB, PCSource, IRWrite, PCWrite, MemRead,
           MemWrite, RegWrite, MemtoReg, Reg2Loc, InstrDone, Illegal, InstrCount
  );
endinterface

// File: rtl/legv8_multicycle_control.sv
// LEGv8 multicycle main control FSM. Sequences each instruction through
// fetch/decode/execute/memory/writeback, drives the datapath enables, flags
// undecodable opcodes (sticky) and counts retired instructions (saturating).
// State-dependent outputs are registered from the next state; only Reg2Loc in
// DECODE/MEM_ADDR (depends on the opcode, which the IR loads at the FETCH edge)
// and PCWrite in CBZ (depends on Zero) are formed combinationally.
module legv8_multicycle_control #(
  parameter int COUNT_W = 16
) (
  input  logic CLK,
  input  logic Reset_L,
  legv8_multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, WB_MEM, MEM_WRITE,
    EXEC_R, WB_R, CBZ, BR, HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_LDUR, CLS_STUR, CLS_RTYPE, CLS_CBZ, CLS_B, CLS_ILLEGAL
  } class_t;

  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       pcsource;
    logic       irwrite;
    logic       pcwrite;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       reg2loc;
    logic       instrdone;
  } ctrl_t;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t             state;
  state_t             next_state;
  class_t             cls;
  class_t             op_class;
  ctrl_t              ctrl_q;
  ctrl_t              ctrl_next;
  logic               illegal_q;
  logic               reg2loc_dyn;
  logic [COUNT_W-1:0] count;

  // Classify the current opcode; anything not explicitly recognised is illegal.
  always_comb begin
    op_class = CLS_ILLEGAL;
    if (bus.Opcode == OP_LDUR)
      op_class = CLS_LDUR;
    else if (bus.Opcode == OP_STUR)
      op_class = CLS_STUR;
    else if (bus.Opcode[10:3] == 8'b10110100)
      op_class = CLS_CBZ;
    else if (bus.Opcode[10:5] == 6'b000101)
      op_class = CLS_B;
    else if (bus.Opcode == OP_ADD || bus.Opcode == OP_SUB ||
             bus.Opcode == OP_AND || bus.Opcode == OP_ORR)
      op_class = CLS_RTYPE;
  end

  // Next-state selection; DECODE dispatches on the live opcode class and
  // MEM_ADDR on the class latched when DECODE ended.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     next_state = FETCH;
      FETCH:    next_state = DECODE;
      DECODE: begin
        case (op_class)
          CLS_LDUR, CLS_STUR: next_state = MEM_ADDR;
          CLS_RTYPE:          next_state = EXEC_R;
          CLS_CBZ:            next_state = CBZ;
          CLS_B:              next_state = BR;
          default:            next_state = HALT;
        endcase
      end
      MEM_ADDR: next_state = (cls == CLS_STUR) ? MEM_WRITE : MEM_READ;
      MEM_READ: next_state = WB_MEM;
      EXEC_R:   next_state = WB_R;
      WB_MEM, MEM_WRITE, WB_R, CBZ, BR: next_state = FETCH;
      HALT:     next_state = HALT;
      default:  next_state = IDLE;
    endcase
  end

  // Moore output table for the state about to be entered, so the outputs can be
  // held in flops and still line up with the state they belong to.
  always_comb begin
    ctrl_next = '0;
    case (next_state)
      FETCH: begin
        ctrl_next.memread = 1'b1;
        ctrl_next.irwrite = 1'b1;
        ctrl_next.alusrcb = 2'b01;
        ctrl_next.pcwrite = 1'b1;
      end
      DECODE: begin
        ctrl_next.alusrcb = 2'b11;
      end
      MEM_ADDR: begin
        ctrl_next.alusrca = 1'b1;
        ctrl_next.alusrcb = 2'b10;
      end
      MEM_READ: begin
        ctrl_next.memread = 1'b1;
      end
      WB_MEM: begin
        ctrl_next.regwrite  = 1'b1;
        ctrl_next.memtoreg  = 1'b1;
        ctrl_next.instrdone = 1'b1;
      end
      MEM_WRITE: begin
        ctrl_next.memwrite  = 1'b1;
        ctrl_next.reg2loc   = 1'b1;
        ctrl_next.instrdone = 1'b1;
      end
      EXEC_R: begin
        ctrl_next.alusrca = 1'b1;
        ctrl_next.aluop   = 2'b10;
      end
      WB_R: begin
        ctrl_next.regwrite  = 1'b1;
        ctrl_next.instrdone = 1'b1;
      end
      CBZ: begin
        ctrl_next.alusrca   = 1'b1;
        ctrl_next.aluop     = 2'b01;
        ctrl_next.reg2loc   = 1'b1;
        ctrl_next.pcsource  = 1'b1;
        ctrl_next.instrdone = 1'b1;
      end
      BR: begin
        ctrl_next.pcsource  = 1'b1;
        ctrl_next.pcwrite   = 1'b1;
        ctrl_next.instrdone = 1'b1;
      end
      default: ctrl_next = '0;
    endcase
  end

  // Reg2Loc while the store/compare register operand is being read depends on
  // the opcode the IR only presents after the FETCH edge, so it stays combinational.
  always_comb begin
    reg2loc_dyn = 1'b0;
    if (state == DECODE)
      reg2loc_dyn = (op_class == CLS_STUR) || (op_class == CLS_CBZ);
    else if (state == MEM_ADDR)
      reg2loc_dyn = (bus.Opcode == OP_STUR);
  end

  // State, latched class, registered outputs, sticky illegal flag and the
  // saturating retired-instruction counter.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= IDLE;
      cls       <= CLS_NONE;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
      count     <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= ctrl_next;
      if (state == DECODE)
        cls <= op_class;
      if (next_state == HALT)
        illegal_q <= 1'b1;
      if (ctrl_q.instrdone && count != COUNT_MAX)
        count <= count + COUNT_W'(1);
    end
  end

  assign bus.ALUop      = ctrl_q.aluop;
  assign bus.ALUSrcA    = ctrl_q.alusrca;
  assign bus.ALUSrcB    = ctrl_q.alusrcb;
  assign bus.PCSource   = ctrl_q.pcsource;
  assign bus.IRWrite    = ctrl_q.irwrite;
  assign bus.PCWrite    = ctrl_q.pcwrite | ((state == CBZ) & bus.Zero);
  assign bus.MemRead    = ctrl_q.memread;
  assign bus.MemWrite   = ctrl_q.memwrite;
  assign bus.RegWrite   = ctrl_q.regwrite;
  assign bus.MemtoReg   = ctrl_q.memtoreg;
  assign bus.Reg2Loc    = ctrl_q.reg2loc | reg2loc_dyn;
  assign bus.InstrDone  = ctrl_q.instrdone;
  assign bus.Illegal    = illegal_q;
  assign bus.InstrCount = count;

endmodule

// File: doc/legv8_multicycle_control.md
# legv8_multicycle_control

Multicycle main control FSM for the LEGv8 datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath enable, and it produces the 2-bit ALUop consumed directly by ALUControl: 00 for add/address, 01 for CBZ pass-B, 10 for R-type decode via Opcode. It also flags illegal opcodes and counts retired instructions.

## Interface
- COUNT_W, 16, width of retired-instruction counter
- CLK  in  1  rising-edge clock
- Reset_L  in  1  asynchronous active-low reset
- Opcode  in  11  instruction bits [31:21] from IR, stable after FETCH
- Zero  in  1  ALU zero flag, sampled in CBZ state
- ALUop  out  2  to ALUControl
- ALUSrcA  out  1  0=PC, 1=register A
- ALUSrcB  out  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext offset<<2
- PCSource  out  1  0=ALU result, 1=ALUOut register
- IRWrite, PCWrite, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc  out  1 each  datapath enables/selects
- InstrDone  out  1  one-cycle pulse on the final cycle of each instruction
- Illegal  out  1  sticky; set on undecodable opcode
- InstrCount  out  COUNT_W  retired instructions, saturating

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, WB_MEM, MEM_WRITE, EXEC_R, WB_R, CBZ, BR, HALT.
- Reset (Reset_L=0, any time, asynchronous): state=IDLE, class register cleared, Illegal=0, InstrCount=0. In IDLE every output is 0. IDLE -> FETCH unconditionally.
- The decode class is latched at the DECODE edge:
  - LDUR 11111000010
  - STUR 11111000000
  - CBZ 10110100xxx
  - B 000101xxxxx
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - anything else is illegal.
- Outputs are Moore-decoded from state. The only exception is PCWrite in CBZ, which is Mealy on Zero. Any output not listed for a state is 0.
  - FETCH: MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSource=0, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUop=00 (branch target to ALUOut). Reg2Loc=1 if Opcode is STUR or CBZ.
  - MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUop=00. Reg2Loc=1 for STUR.
  - MEM_READ: MemRead=1.
  - WB_MEM: RegWrite=1, MemtoReg=1, InstrDone=1.
  - MEM_WRITE: MemWrite=1, Reg2Loc=1, InstrDone=1.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - WB_R: RegWrite=1, MemtoReg=0, InstrDone=1.
  - CBZ: ALUSrcA=1, ALUSrcB=00, ALUop=01, Reg2Loc=1, PCSource=1, PCWrite=Zero, InstrDone=1.
  - BR: PCSource=1, PCWrite=1, InstrDone=1.
  - HALT: Illegal=1, all else 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE -> MEM_ADDR for LDUR/STUR, EXEC_R for R-type, CBZ for CBZ, BR for B, HALT for illegal.
  - MEM_ADDR -> MEM_READ for LDUR, MEM_WRITE for STUR.
  - MEM_READ -> WB_MEM.
  - EXEC_R -> WB_R.
  - WB_MEM, MEM_WRITE, WB_R, CBZ and BR all -> FETCH.
  - HALT -> HALT until reset.
- Illegal is set on entry to HALT and held until Reset_L=0.
- InstrCount increments by 1 on every clock edge where InstrDone=1. It holds at 2^COUNT_W-1 and does not wrap. Illegal instructions are not counted.

## Timing
- Cycles per instruction, counted from the FETCH cycle:
  - R-type 4
  - LDUR 5
  - STUR 4
  - CBZ 3
  - B 3
- The next FETCH follows immediately, with no bubble.
- Opcode is sampled only in DECODE (for class and Reg2Loc) and MEM_ADDR (for Reg2Loc).
- Zero is sampled combinationally in the CBZ cycle only.
- The first FETCH occurs in the second cycle after Reset_L deasserts.
- InstrCount updates on the edge ending the InstrDone cycle and is visible the following cycle.
- Reset asserted mid-instruction aborts it with no InstrDone and no count increment. All outputs go to 0 immediately, asynchronously.

## Test plan
- Reset, then ADD (10001011000): sequence IDLE, FETCH, DECODE, EXEC_R, WB_R. Required: ALUop=10 only in EXEC_R; RegWrite=1, InstrDone=1 in WB_R; InstrCount=1 afterwards.
- LDUR (11111000010) then STUR (11111000000):
  - LDUR takes 5 cycles, with MemRead=1 in FETCH and MEM_READ, and MemtoReg=1 with RegWrite=1 in WB_MEM.
  - STUR takes 4 cycles, with MemWrite=1 for exactly one cycle and Reg2Loc=1 in DECODE through MEM_WRITE.
  - InstrCount=2.
- CBZ (10110100000) twice:
  - With Zero=0, PCWrite=0 in the CBZ cycle.
  - With Zero=1, PCWrite=1 and PCSource=1.
  - Both cases: ALUop=01, 3 cycles each.
- B (00010100000): 3 cycles, PCWrite=1 with PCSource=1 in BR. Then illegal 11111111111: HALT, Illegal=1 sticky for 20 cycles, InstrCount unchanged. Pulse Reset_L: Illegal=0, InstrCount=0.
- Reset_L pulsed low during MEM_READ of an LDUR. Required: outputs go to 0 at once, no InstrDone, count unchanged at 0, restart at IDLE -> FETCH.
- With COUNT_W=2, run 5 R-type instructions. Required: InstrCount reads 1, 2, 3, 3, 3.
